// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core-side ports (fetch m0, LSU m1), the shared memory
// and the mem_port_arbiter. The slave modport is the arbiter's view of the bundle.
interface mem_port_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wd_i;
  logic [31:0] m0_rd_o;
  logic        m0_ready_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wd_i;
  logic [31:0] m1_rd_o;
  logic        m1_ready_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        err_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    input  mem_rd_i, mem_ready_i,
    output m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, err_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    output mem_rd_i, mem_ready_i,
    input  m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (m0) and LSU (m1).
// Optional per-transaction timeout is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

  state_t state;
  logic   last_grant;
  logic   busy, start, done, tmo;

  assign busy  = (state != IDLE);
  assign start = (state == IDLE) && (bus.m0_req_i || bus.m1_req_i);
  assign done  = busy && (bus.mem_ready_i || tmo);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  // Cleared on every entry into a BUSY state, including the direct hand-over.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            cnt <= '0;
    else if (start || done) cnt <= '0;
    else if (busy)          cnt <= cnt + CW'(1);
  end

  assign tmo = busy && !bus.mem_ready_i && (cnt == CW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  // A completing port is never re-granted directly; it must pass through IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req_i && (!bus.m1_req_i || last_grant)) state <= BUSY0;
          else if (bus.m1_req_i)                             state <= BUSY1;
        end
        BUSY0: begin
          if (done) begin
            last_grant <= 1'b0;
            state      <= bus.m1_req_i ? BUSY1 : IDLE;
          end
        end
        BUSY1: begin
          if (done) begin
            last_grant <= 1'b1;
            state      <= bus.m0_req_i ? BUSY0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req_o  = busy;
    bus.mem_we_o   = 1'b0;
    bus.mem_be_o   = 4'h0;
    bus.mem_addr_o = 32'h0;
    bus.mem_wd_o   = 32'h0;
    case (state)
      BUSY0: begin
        bus.mem_we_o   = bus.m0_we_i;
        bus.mem_be_o   = bus.m0_be_i;
        bus.mem_addr_o = bus.m0_addr_i;
        bus.mem_wd_o   = bus.m0_wd_i;
      end
      BUSY1: begin
        bus.mem_we_o   = bus.m1_we_i;
        bus.mem_be_o   = bus.m1_be_i;
        bus.mem_addr_o = bus.m1_addr_i;
        bus.mem_wd_o   = bus.m1_wd_i;
      end
      default: ;
    endcase

    bus.m0_rd_o    = bus.mem_rd_i;
    bus.m1_rd_o    = bus.mem_rd_i;
    bus.m0_ready_o = done && (state == BUSY0);
    bus.m1_ready_o = done && (state == BUSY1);
    bus.err_o      = tmo;
    // A timed-out transaction returns a poison word to its own port only.
    if (tmo) begin
      if (state == BUSY0) bus.m0_rd_o = 32'hDEAD_BEEF;
      else                bus.m1_rd_o = 32'hDEAD_BEEF;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Stimulus state for both requesters and the memory.
  logic        rq[2];
  logic        wev[2];
  logic [3:0]  bev[2];
  logic [31:0] adv[2];
  logic [31:0] wdv[2];
  logic        mr_val;
  logic [31:0] rd_val;

  // Reference model: current owner (-1 none), last winner, wait count.
  int   own, last, cnt;
  logic m_done, m_to;

  typedef struct {
    logic        r0, r1, mr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        erdy0, erdy1;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply();
    bus.m0_req_i = rq[0];  bus.m0_we_i = wev[0]; bus.m0_be_i = bev[0];
    bus.m0_addr_i = adv[0]; bus.m0_wd_i = wdv[0];
    bus.m1_req_i = rq[1];  bus.m1_we_i = wev[1]; bus.m1_be_i = bev[1];
    bus.m1_addr_i = adv[1]; bus.m1_wd_i = wdv[1];
    bus.mem_ready_i = mr_val; bus.mem_rd_i = rd_val;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    own = -1; last = 1; cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wev[p] = 1'b0; bev[p] = 4'h0; adv[p] = 32'h0; wdv[p] = 32'h0;
    end
    mr_val = 1'b0; rd_val = 32'h0;
    apply();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic new_fields(input int p);
    adv[p] = $urandom; wev[p] = 1'($urandom_range(1));
    bev[p] = 4'($urandom); wdv[p] = $urandom;
  endtask

  task automatic model_check(input string tag);
    logic b, ewe;
    logic [3:0] eb;
    logic [31:0] ea, ew, er0, er1;
    b = (own >= 0);
    m_to = TO_EN && b && !mr_val && (cnt == TO);
    m_done = b && (mr_val || m_to);
    ewe = 1'b0; eb = 4'h0; ea = 32'h0; ew = 32'h0;
    if (b) begin ewe = wev[own]; eb = bev[own]; ea = adv[own]; ew = wdv[own]; end
    er0 = rd_val; er1 = rd_val;
    if (m_to && own == 0) er0 = 32'hDEAD_BEEF;
    if (m_to && own == 1) er1 = 32'hDEAD_BEEF;
    chk({tag, ".req"},  32'(bus.mem_req_o),  32'(b));
    chk({tag, ".addr"}, bus.mem_addr_o,      ea);
    chk({tag, ".we"},   32'(bus.mem_we_o),   32'(ewe));
    chk({tag, ".be"},   32'(bus.mem_be_o),   32'(eb));
    chk({tag, ".wd"},   bus.mem_wd_o,        ew);
    chk({tag, ".rdy0"}, 32'(bus.m0_ready_o), 32'(m_done && own == 0));
    chk({tag, ".rdy1"}, 32'(bus.m1_ready_o), 32'(m_done && own == 1));
    chk({tag, ".rd0"},  bus.m0_rd_o,         er0);
    chk({tag, ".rd1"},  bus.m1_rd_o,         er1);
    chk({tag, ".err"},  32'(bus.err_o),      32'(m_to));
  endtask

  task automatic model_step();
    if (own < 0) begin
      cnt = 0;
      if (rq[0] && rq[1]) own = 1 - last;
      else if (rq[0])     own = 0;
      else if (rq[1])     own = 1;
    end else if (m_done) begin
      last = own;
      own  = rq[1 - own] ? 1 - own : -1;
      cnt  = 0;
    end else begin
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, dp;
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};

    // Reset state, with live inputs pushing against it.
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b1; wev[p] = 1'b1; bev[p] = 4'hF; adv[p] = 32'h40 << p; wdv[p] = 32'h55;
    end
    mr_val = 1'b1; rd_val = 32'h0;
    apply();
    #12;
    chk("rst.req",  32'(bus.mem_req_o),  32'h0);
    chk("rst.we",   32'(bus.mem_we_o),   32'h0);
    chk("rst.be",   32'(bus.mem_be_o),   32'h0);
    chk("rst.addr", bus.mem_addr_o,      32'h0);
    chk("rst.wd",   bus.mem_wd_o,        32'h0);
    chk("rst.rdy0", 32'(bus.m0_ready_o), 32'h0);
    chk("rst.rdy1", 32'(bus.m1_ready_o), 32'h0);
    chk("rst.err",  32'(bus.err_o),      32'h0);

    // Vector table.
    do_reset();
    adv[0] = 32'h100; adv[1] = 32'h200; bev[0] = 4'hF; bev[1] = 4'h3; wev[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rq[0] = tv[i].r0; rq[1] = tv[i].r1; mr_val = tv[i].mr; rd_val = 32'hA000_0000 + 32'(i);
      apply(); #1;
      chk($sformatf("tv%0d.req", i),  32'(bus.mem_req_o),  32'(tv[i].ereq));
      chk($sformatf("tv%0d.addr", i), bus.mem_addr_o,      tv[i].eaddr);
      chk($sformatf("tv%0d.rdy0", i), 32'(bus.m0_ready_o), 32'(tv[i].erdy0));
      chk($sformatf("tv%0d.rdy1", i), 32'(bus.m1_ready_o), 32'(tv[i].erdy1));
      chk($sformatf("tv%0d.rd0", i),  bus.m0_rd_o,         rd_val);
      tick();
    end

    // Single m0 read, memory answers one cycle after mem_req_o.
    do_reset();
    rq[0] = 1'b1; adv[0] = 32'h0000_0100; bev[0] = 4'hF;
    apply(); #1;
    chk("rd.req_t", 32'(bus.mem_req_o), 32'h0);
    tick();
    chk("rd.req_t1", 32'(bus.mem_req_o), 32'h1);
    chk("rd.addr",   bus.mem_addr_o,     32'h0000_0100);
    chk("rd.rdy_t1", 32'(bus.m0_ready_o), 32'h0);
    tick();
    mr_val = 1'b1; rd_val = 32'h1234_5678; apply(); #1;
    chk("rd.rdy", 32'(bus.m0_ready_o), 32'h1);
    chk("rd.data", bus.m0_rd_o, 32'h1234_5678);
    tick();
    rq[0] = 1'b0; mr_val = 1'b0; apply(); #1;
    chk("rd.idle_req", 32'(bus.mem_req_o),  32'h0);
    chk("rd.idle_rdy", 32'(bus.m0_ready_o), 32'h0);

    // Continuous contention, latency 2: strict alternation without bubbles.
    do_reset();
    rq[0] = 1'b1; rq[1] = 1'b1; adv[0] = 32'h1000; adv[1] = 32'h2000;
    apply(); tick();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      mr_val = 1'b0; apply(); #1;
      chk($sformatf("alt%0d.addr", k), bus.mem_addr_o, (k % 2) ? 32'h2000 : 32'h1000);
      n0 += int'(bus.m0_ready_o); n1 += int'(bus.m1_ready_o);
      tick();
      mr_val = 1'b1; apply(); #1;
      chk($sformatf("alt%0d.rdy0", k), 32'(bus.m0_ready_o), 32'(k % 2 == 0));
      chk($sformatf("alt%0d.rdy1", k), 32'(bus.m1_ready_o), 32'(k % 2 == 1));
      n0 += int'(bus.m0_ready_o); n1 += int'(bus.m1_ready_o);
      tick();
    end
    chk("alt.n0", 32'(n0), 32'd3);
    chk("alt.n1", 32'(n1), 32'd3);

    // m1 store, latency 3: fields stable, one pulse on the third cycle.
    do_reset();
    rq[1] = 1'b1; wev[1] = 1'b1; bev[1] = 4'b0100; wdv[1] = 32'h00AB_0000; adv[1] = 32'h300;
    apply(); tick();
    for (int i = 0; i < 3; i++) begin
      mr_val = (i == 2); apply(); #1;
      chk($sformatf("st%0d.we", i),   32'(bus.mem_we_o),   32'h1);
      chk($sformatf("st%0d.be", i),   32'(bus.mem_be_o),   32'h4);
      chk($sformatf("st%0d.wd", i),   bus.mem_wd_o,        32'h00AB_0000);
      chk($sformatf("st%0d.rdy1", i), 32'(bus.m1_ready_o), 32'(i == 2));
      chk($sformatf("st%0d.rdy0", i), 32'(bus.m0_ready_o), 32'h0);
      tick();
    end

    // Asynchronous reset in the middle of a BUSY1 transaction.
    do_reset();
    rq[1] = 1'b1; adv[1] = 32'h500; adv[0] = 32'h600;
    apply(); tick(); #1;
    chk("ar.busy", 32'(bus.mem_req_o), 32'h1);
    mr_val = 1'b1; apply();
    rst_n = 1'b0; #1;
    chk("ar.req",  32'(bus.mem_req_o),  32'h0);
    chk("ar.rdy1", 32'(bus.m1_ready_o), 32'h0);
    chk("ar.rdy0", 32'(bus.m0_ready_o), 32'h0);
    tick();
    rst_n = 1'b1; model_reset();
    rq[0] = 1'b1; rq[1] = 1'b1; mr_val = 1'b0; apply(); tick(); #1;
    chk("ar.tie_req",  32'(bus.mem_req_o), 32'h1);
    chk("ar.tie_addr", bus.mem_addr_o,     32'h600);

    // Memory never responds to m0.
    do_reset();
    rq[0] = 1'b1; adv[0] = 32'h700; rd_val = 32'h0BAD_0000;
    apply(); tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 0; k <= TO; k++) begin
      #1;
      chk($sformatf("to%0d.rdy0", k), 32'(bus.m0_ready_o), 32'(k == TO));
      chk($sformatf("to%0d.err", k),  32'(bus.err_o),      32'(k == TO));
      chk($sformatf("to%0d.rd0", k),  bus.m0_rd_o, (k == TO) ? 32'hDEAD_BEEF : 32'h0BAD_0000);
      tick();
    end
    rq[0] = 1'b0; mr_val = 1'b1; apply(); #1;
    chk("to.idle_req", 32'(bus.mem_req_o),  32'h0);
    chk("to.late_rdy", 32'(bus.m0_ready_o), 32'h0);
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("nto%0d.err", k), 32'(bus.err_o),     32'h0);
      chk($sformatf("nto%0d.req", k), 32'(bus.mem_req_o), 32'h1);
      tick();
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mr_val = ($urandom_range(2) == 0);
      rd_val = $urandom;
      apply(); #1;
      model_check("rnd");
      dp = m_done ? own : -1;
      model_step();
      for (int p = 0; p < 2; p++) begin
        if (rq[p]) begin
          if (dp == p) begin
            rq[p] = 1'($urandom_range(1));
            if (rq[p]) new_fields(p);
          end
        end else if ($urandom_range(9) < 4) begin
          rq[p] = 1'b1;
          new_fields(p);
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one single-port data/instruction memory between the instruction-fetch port (m0) and the load/store unit memory port (m1).
- Sits between the core-side masters and the memory.
- Grants one transaction at a time, holds the grant until the memory completes it, and alternates round-robin when both requesters contend.
- Per-port signal set matches the LSU memory interface: req, we, be, addr, wd, rd, ready.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a granted transaction may wait for mem_ready_i. Used only when MEM_ARB_TIMEOUT_EN is defined. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_req_i  in  1  fetch-port request; held with stable fields until m0_ready_o.
- m0_we_i  in  1  fetch-port write enable.
- m0_be_i  in  4  fetch-port byte enables.
- m0_addr_i  in  32  fetch-port address.
- m0_wd_i  in  32  fetch-port write data.
- m0_rd_o  out  32  fetch-port read data; valid only when m0_ready_o=1.
- m0_ready_o  out  1  fetch-port transaction complete, one-cycle pulse.
- m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i, m1_rd_o, m1_ready_o: LSU port, same widths and semantics as the m0 port.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  32  memory address.
- mem_wd_o  out  32  memory write data.
- mem_rd_i  in  32  memory read data.
- mem_ready_i  in  1  memory completion, one-cycle pulse.
- err_o  out  1  timeout error pulse.

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, last_grant (1 bit), timeout counter when the option is enabled.
- Reset (rst_ni=0, takes effect asynchronously):
  - state=IDLE, last_grant=1, so m0 wins the first tie.
  - mem_req_o=0, m0_ready_o=0, m1_ready_o=0, err_o=0.
  - mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0.
  - An in-flight transaction is abandoned and is not reported to its requester.
- IDLE:
  - mem_req_o=0; all mem_* outputs are 0.
  - Only m0_req_i=1 -> BUSY0. Only m1_req_i=1 -> BUSY1.
  - Both requests high -> grant the port not equal to last_grant.
- BUSYx:
  - mem_req_o=1; mem_we/be/addr/wd_o are driven combinationally from port x's inputs.
  - The non-granted port sees ready_o=0.
- Completion (mem_ready_i=1 while in BUSYx):
  - mx_ready_o=1 combinationally in the same cycle; last_grant<=x.
  - Next state is BUSY(other) if the other port's req is high in that cycle, otherwise IDLE.
  - The completing port is never re-granted directly from completion. A requester reissuing back-to-back passes through IDLE, so each new request costs one cycle when uncontended.
- mem_ready_i while IDLE is ignored; no ready_o pulse is produced.
- m0_rd_o and m1_rd_o both equal mem_rd_i at all times. They are meaningful only alongside their ready_o.
- Latency:
  - Request seen in IDLE at cycle t -> mem_req_o=1 at t+1.
  - Earliest ready_o is t+1, when memory responds in the same cycle.
- Fairness: under continuous contention the grants strictly alternate m0, m1, m0, ...
- A requester dropping req while granted is a protocol violation. The arbiter keeps the grant until mem_ready_i.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - The counter clears on entry to BUSYx and increments every BUSYx cycle without mem_ready_i.
  - When the counter equals TIMEOUT_CYCLES and mem_ready_i=0, that cycle acts as a completion for port x: mx_ready_o=1, mx_rd_o=32'hDEAD_BEEF, err_o=1.
  - The grant is released by the normal completion rule.
  - A late mem_ready_i arriving in IDLE is ignored.
- When not defined: no counter is built, err_o is tied to 0, and a transaction waits indefinitely.

Test Plan:
- Single m0 read at 0x0000_0100; memory answers ready one cycle after mem_req_o with rd=0x1234_5678 -> mem_req_o rises the cycle after m0_req_i, m0_ready_o pulses once, m0_rd_o=0x1234_5678, then state returns to IDLE.
- m0 and m1 both request in the same IDLE cycle after reset -> m0 is granted first. On m0 completion the next cycle is BUSY1 with mem_addr_o=m1_addr_i and no IDLE bubble.
- Both requests held high for 6 transactions, memory latency 2 -> grant order m0, m1, m0, m1, m0, m1. Each ready_o pulses exactly once per transaction.
- m1 store (we=1, be=4'b0100, wd=0x00AB_0000), memory latency 3 -> mem_we_o, mem_be_o and mem_wd_o are stable for all 3 cycles; m1_ready_o pulses on the third; m0_ready_o stays 0.
- rst_ni asserted low mid-BUSY1 -> mem_req_o drops asynchronously and neither ready_o pulses. After release, the next tie goes to m0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never responds to m0 -> m0_ready_o=1, m0_rd_o=0xDEAD_BEEF and err_o=1 on the timeout cycle, followed by IDLE. Without the macro, err_o stays 0 and mem_req_o stays high.
